serial_word_deserializer: RTL
=============================

// Module: serial_word_deserializer
// PURPOSE
//  Receive end of the team's serial link: rebuilds WIDTH-bit words from a
//  1-bit stream produced by the parallel-load/shift universal shift register.
//  The bit order is chosen per frame (LSB-first or MSB-first).
//  Each completed word goes into an output holding register, then leaves
//  through a valid/ready handshake. Overrun and framing errors are flagged.
// PARAMETERS
//  WIDTH  4  word width in bits, >= 2
// PORTS
//  CLK          in   1                 clock; all state changes on posedge
//  Clear_b      in   1                 async active-low reset, sync deassert upstream
//  ser_in       in   1                 serial data bit
//  ser_valid    in   1                 ser_in is valid this cycle (low = hold)
//  frame_start  in   1                 qualifies first bit of a word; needs ser_valid=1
//  lsb_first    in   1                 sampled with frame_start: 1 = LSB-first, 0 = MSB-first
//  out_data     out  WIDTH             assembled word; stable while out_valid=1
//  out_valid    out  1                 out_data holds an unconsumed word
//  out_ready    in   1                 consumer accepts; transfer when out_valid & out_ready
//  overrun      out  1                 sticky: completed word dropped, holding reg full
//  frame_err    out  1                 sticky: frame_start arrived before word complete
//  err_clr      in   1                 synchronous clear of overrun and frame_err
//  bit_cnt      out  $clog2(WIDTH+1)   bits received in current frame
// BEHAVIOUR
//  Reset (Clear_b=0, async): state=IDLE, shift reg=0, bit_cnt=0, out_data=0,
//    out_valid=0, overrun=0, frame_err=0, dir latch=0.
//  FSM IDLE:
//    - ser_valid & frame_start: latch lsb_first, shift in bit, bit_cnt=1, go to RECV.
//    - ser_valid without frame_start: ignored, no error.
//  FSM RECV:
//    - ser_valid=0: hold everything.
//    - ser_valid=1, no frame_start: shift in bit, bit_cnt+1.
//    - LSB-first shift: sh <= {ser_in, sh[WIDTH-1:1]}
//    - MSB-first shift: sh <= {sh[WIDTH-2:0], ser_in}
//    - Bit number WIDTH accepted: word complete. Next cycle the completed word is
//      offered to the holding reg, state=IDLE, bit_cnt=0.
//    - frame_start & ser_valid before bit WIDTH: partial word discarded, frame_err=1.
//      The new frame starts with this bit (bit_cnt=1, dir re-latched).
//  Holding register:
//    - Latency: last bit sampled at edge N gives out_valid=1 after edge N+1.
//    - Word complete, out_valid=0: load word, out_valid=1.
//    - Word complete, out_valid=1 & out_ready=1: load word, out_valid stays 1
//      (back-to-back words, no bubble).
//    - Word complete, out_valid=1 & out_ready=0: drop new word, keep held word
//      unchanged, overrun=1.
//    - No word complete, out_valid & out_ready: out_valid=0, out_data keeps last value.
//  Errors:
//    - err_clr=1 clears both flags.
//    - A new error event in the same cycle as err_clr wins: flag set.
//  Serial side has no backpressure: every valid bit in RECV is consumed.
//  out_data never changes while out_valid=1 and out_ready=0.
//  Reset mid-frame or mid-handshake: immediate return to reset values; the
//    partial word and the held word are both lost.
// STRUCTURE
//  Package shift_pkg:
//    - typedef enum logic {IDLE, RECV} deser_state_t
//    - localparam bit DIR_LSB_FIRST = 1'b1, DIR_MSB_FIRST = 1'b0
//  One natural sub-module: word_hold_reg (WIDTH-bit valid/ready holding stage
//    with drop-on-full flag). It may be inlined if the top stays under 200 lines.
// TESTING (WIDTH=4)
//  1. LSB-first, bits 1,0,1,1 back-to-back, out_ready=1
//     -> out_data=4'b1101, out_valid one cycle, 1 cycle after bit 4.
//  2. MSB-first, bits 1,0,1,1 with ser_valid gaps, out_ready=1
//     -> out_data=4'b1011; bit_cnt holds across gaps.
//  3. Two words 4'hA then 4'h5, out_ready=0 throughout
//     -> out_data stays 4'hA, overrun=1.
//     -> Then err_clr=1 gives overrun=0; out_ready=1 gives one transfer of 4'hA.
//  4. frame_start after 2 bits, then 4 bits 0,1,1,0 LSB-first
//     -> frame_err=1, out_data=4'b0110, no word from partial frame.
//  5. Clear_b=0 asynchronously after 3 bits, release, send full word 4'h3
//     -> all outputs 0 immediately; out_data=4'h3 afterwards.
//  6. Word complete in same cycle as out_valid & out_ready
//     -> new word replaces old, out_valid stays 1, no overrun.

Source files
------------

// File: rtl/serial_word_deserializer_pkg.sv
// Shared types and constants for the serial word deserializer.
package shift_pkg;

    typedef enum logic {IDLE, RECV} deser_state_t;

    localparam bit DIR_LSB_FIRST = 1'b1;
    localparam bit DIR_MSB_FIRST = 1'b0;

endpackage

// File: rtl/serial_word_deserializer_if.sv
// Serial-in / word-out bundle of the deserializer; master drives the serial side and consumes words.
interface serial_word_deserializer_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             ser_in;
    logic             ser_valid;
    logic             frame_start;
    logic             lsb_first;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             frame_err;
    logic             err_clr;
    logic [CW-1:0]    bit_cnt;

    modport master (
        output ser_in, ser_valid, frame_start, lsb_first, out_ready, err_clr,
        input  out_data, out_valid, overrun, frame_err, bit_cnt
    );

    modport slave (
        input  ser_in, ser_valid, frame_start, lsb_first, out_ready, err_clr,
        output out_data, out_valid, overrun, frame_err, bit_cnt
    );
endinterface

// File: rtl/serial_word_deserializer_hold.sv
// One-entry valid/ready holding stage; a load that finds it full and not draining is dropped.
module word_hold_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             drop
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        drop    = 1'b0;
        if (load) begin
            // A draining entry frees the slot in the same cycle, so no bubble.
            if (!valid_q || ready) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
endmodule

// File: rtl/serial_word_deserializer.sv
// Rebuilds WIDTH-bit words from a framed 1-bit stream (per-frame bit order) and hands them off via valid/ready.
module serial_word_deserializer
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                        CLK,
    input  logic                        Clear_b,
    serial_word_deserializer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    deser_state_t     state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic             take;
    logic             ferr_evt;
    logic [WIDTH-1:0] shift_src;
    logic             drop;
    logic [WIDTH-1:0] hold_data;
    logic             hold_valid;

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        take      = 1'b0;
        ferr_evt  = 1'b0;
        shift_src = sh_q;
        if (bus.ser_valid) begin
            if (bus.frame_start) begin
                // A frame start always restarts; mid-frame it abandons the partial word.
                take      = 1'b1;
                ferr_evt  = (state_q == RECV);
                dir_d     = bus.lsb_first;
                shift_src = '0;
                cnt_d     = CW'(1);
                state_d   = RECV;
            end else if (state_q == RECV) begin
                take  = 1'b1;
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (take) begin
            if (dir_d == DIR_LSB_FIRST) sh_d = {bus.ser_in, shift_src[WIDTH-1:1]};
            else                        sh_d = {shift_src[WIDTH-2:0], bus.ser_in};
            if (cnt_d == CNT_FULL) begin
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
        end
        // A fresh error in the clearing cycle takes priority over the clear.
        frame_err_d = ferr_evt | (frame_err_q & ~bus.err_clr);
        overrun_d   = drop     | (overrun_q   & ~bus.err_clr);
    end

    always_ff @(posedge CLK or negedge Clear_b) begin
        if (!Clear_b) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // The completed word sits in sh_q for the cycle after its last bit and is offered here.
    word_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk   (CLK),
        .rst_n (Clear_b),
        .load  (done_q),
        .word  (sh_q),
        .ready (bus.out_ready),
        .data  (hold_data),
        .valid (hold_valid),
        .drop  (drop)
    );

    assign bus.out_data  = hold_data;
    assign bus.out_valid = hold_valid;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
    assign bus.bit_cnt   = cnt_q;
endmodule
